// File: rtl/filter_engine_pkg.sv
// Shared types for the PNG scanline filter engine: filter-type codes, FSM states
// and the config legalisation helper.
package filter_engine_pkg;

  localparam int DATA_WD_DEF = 8;

  typedef enum logic [2:0] {
    FLT_NONE  = 3'd0,
    FLT_SUB   = 3'd1,
    FLT_UP    = 3'd2,
    FLT_AVG   = 3'd3,
    FLT_PAETH = 3'd4
  } flt_typ_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY,
    ST_DONE
  } state_e;

  // Unassigned codes 5..7 fall back to None so the header always names a real filter.
  function automatic flt_typ_e legal_typ(input logic [2:0] raw);
    return (raw > 3'(FLT_PAETH)) ? FLT_NONE : flt_typ_e'(raw);
  endfunction

endpackage

// File: rtl/filter_pred.sv
// Combinational PNG predictor: x' = x - pred(a, b, c) for the selected filter type,
// including the Paeth predictor with a-then-b-then-c tie breaking.
module filter_pred
  import filter_engine_pkg::*;
#(
  parameter int DATA_WD = DATA_WD_DEF
) (
  input  logic [DATA_WD-1:0] x,
  input  logic [DATA_WD-1:0] a,
  input  logic [DATA_WD-1:0] b,
  input  logic [DATA_WD-1:0] c,
  input  flt_typ_e           typ,
  output logic [DATA_WD-1:0] y
);

  localparam int SW = DATA_WD + 2;

  logic signed [SW-1:0] sa, sb, sc;
  logic signed [SW-1:0] da, db, dc;
  logic signed [SW-1:0] pa, pb, pc;
  logic [DATA_WD:0]     sum_ab;
  logic [DATA_WD-1:0]   paeth;
  logic [DATA_WD-1:0]   pred;

  // NOTE: every variable gets a value on every path of an always_comb so no latch is inferred.
  always_comb begin
    sa = $signed({2'b00, a});
    sb = $signed({2'b00, b});
    sc = $signed({2'b00, c});
    // Distances from p = a + b - c rewritten without forming p itself.
    da = sb - sc;
    db = sa - sc;
    dc = sa + sb - sc - sc;
    pa = (da < 0) ? -da : da;
    pb = (db < 0) ? -db : db;
    pc = (dc < 0) ? -dc : dc;

    if (pa <= pb && pa <= pc) paeth = a;
    else if (pb <= pc)        paeth = b;
    else                      paeth = c;

    sum_ab = {1'b0, a} + {1'b0, b};

    unique case (typ)
      FLT_NONE:  pred = '0;
      FLT_SUB:   pred = a;
      FLT_UP:    pred = b;
      FLT_AVG:   pred = sum_ab[DATA_WD:1];
      FLT_PAETH: pred = paeth;
      default:   pred = '0;
    endcase

    y = x - pred;
  end

endmodule

// File: rtl/filter_engine.sv
// Streaming PNG scanline filter: one raw byte in per cycle, filtered rows out, each
// led by its filter-type byte. The previous row is kept in an internal row buffer.
module filter_engine
  import filter_engine_pkg::*;
#(
  parameter int DATA_WD = DATA_WD_DEF,
  parameter int BPP_MAX = 8,
  parameter int ROW_MAX = 4096,
  parameter int LEN_WD  = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         cfg_typ_i,
  input  logic [3:0]         cfg_bpp_i,
  input  logic [LEN_WD-1:0]  cfg_len_i,
  input  logic [LEN_WD-1:0]  cfg_row_i,
  input  logic               dat_val_i,
  output logic               dat_rdy_o,
  input  logic [DATA_WD-1:0] dat_i,
  output logic               flt_val_o,
  input  logic               flt_rdy_i,
  output logic [DATA_WD-1:0] flt_dat_o,
  output logic               flt_sor_o,
  output logic               flt_eof_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int ADDR_WD = $clog2(ROW_MAX);
  localparam int BPP_IW  = (BPP_MAX > 1) ? $clog2(BPP_MAX) : 1;

  state_e              state;
  flt_typ_e            typ_q;
  logic [3:0]          bpp_q;
  logic [LEN_WD-1:0]   len_q;
  logic [LEN_WD-1:0]   rows_q;
  logic [LEN_WD-1:0]   col;
  logic [LEN_WD-1:0]   row;

  logic [DATA_WD-1:0]  left_hist [BPP_MAX];
  logic [DATA_WD-1:0]  up_hist   [BPP_MAX];
  logic [DATA_WD-1:0]  rowbuf    [ROW_MAX];

  logic [BPP_IW-1:0]   tap;
  logic [ADDR_WD-1:0]  col_idx;
  logic                first_row;
  logic                last_col;
  logic                last_row;
  logic                out_free;
  logic                accept;
  logic [DATA_WD-1:0]  nb_a, nb_b, nb_c;
  logic [DATA_WD-1:0]  flt_byte;

  assign out_free  = ~flt_val_o | flt_rdy_i;
  assign dat_rdy_o = (state == ST_BODY) & out_free;
  assign accept    = dat_val_i & dat_rdy_o;
  assign busy_o    = (state != ST_IDLE);

  assign tap       = BPP_IW'(bpp_q - 4'd1);
  assign col_idx   = col[ADDR_WD-1:0];
  assign first_row = (row == '0);
  assign last_col  = (col + LEN_WD'(1) >= len_q);
  assign last_row  = (row + LEN_WD'(1) >= rows_q);

  // Histories are cleared per row, so the tap reads zero until bpp bytes have entered.
  assign nb_a = left_hist[tap];
  assign nb_c = up_hist[tap];
  assign nb_b = first_row ? '0 : rowbuf[col_idx];

  filter_pred #(.DATA_WD(DATA_WD)) u_pred (
    .x   (dat_i),
    .a   (nb_a),
    .b   (nb_b),
    .c   (nb_c),
    .typ (typ_q),
    .y   (flt_byte)
  );

  // NOTE: the row buffer has no reset; stale contents are masked by first_row.
  always_ff @(posedge clk) begin
    if (accept) rowbuf[col_idx] <= dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      typ_q     <= FLT_NONE;
      bpp_q     <= 4'd1;
      len_q     <= '0;
      rows_q    <= '0;
      col       <= '0;
      row       <= '0;
      flt_val_o <= 1'b0;
      flt_dat_o <= '0;
      flt_sor_o <= 1'b0;
      flt_eof_o <= 1'b0;
      done_o    <= 1'b0;
      for (int i = 0; i < BPP_MAX; i++) begin
        left_hist[i] <= '0;
        up_hist[i]   <= '0;
      end
    end else begin
      done_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_i) begin
            typ_q <= legal_typ(cfg_typ_i);
            if (cfg_bpp_i == 4'd0)               bpp_q <= 4'd1;
            else if (cfg_bpp_i > 4'(BPP_MAX))    bpp_q <= 4'(BPP_MAX);
            else                                 bpp_q <= cfg_bpp_i;
            len_q  <= cfg_len_i;
            rows_q <= cfg_row_i;
            col    <= '0;
            row    <= '0;
            state  <= ST_HEAD;
          end
        end

        ST_HEAD: begin
          if (out_free) begin
            flt_dat_o <= {{(DATA_WD-3){1'b0}}, typ_q};
            flt_val_o <= 1'b1;
            flt_sor_o <= 1'b1;
            flt_eof_o <= 1'b0;
            col       <= '0;
            for (int i = 0; i < BPP_MAX; i++) begin
              left_hist[i] <= '0;
              up_hist[i]   <= '0;
            end
            state <= ST_BODY;
          end
        end

        ST_BODY: begin
          if (accept) begin
            flt_dat_o    <= flt_byte;
            flt_val_o    <= 1'b1;
            flt_sor_o    <= 1'b0;
            flt_eof_o    <= last_col & last_row;
            left_hist[0] <= dat_i;
            up_hist[0]   <= nb_b;
            for (int i = 1; i < BPP_MAX; i++) begin
              left_hist[i] <= left_hist[i-1];
              up_hist[i]   <= up_hist[i-1];
            end
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                state <= ST_DONE;
              end else begin
                row   <= row + LEN_WD'(1);
                state <= ST_HEAD;
              end
            end else begin
              col <= col + LEN_WD'(1);
            end
          end else if (flt_rdy_i) begin
            flt_val_o <= 1'b0;
            flt_sor_o <= 1'b0;
          end
        end

        ST_DONE: begin
          if (flt_val_o & flt_rdy_i) begin
            flt_val_o <= 1'b0;
            flt_eof_o <= 1'b0;
            done_o    <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/filter_engine.md
Name: filter_engine

Overview:
- Streaming PNG scanline filter engine: accepts raw image bytes one per cycle and emits filtered scanlines, each preceded by its filter-type byte.
- Supports all five PNG filter types (None, Sub, Up, Average, Paeth) and bytes-per-pixel 1..BPP_MAX.
- Holds the previous scanline internally, so upstream delivers raw rows only.
- Sits between the pixel unpacker and the deflate compressor.

Parameters:
- DATA_WD, 8, sample width in bits (PNG byte).
- BPP_MAX, 8, maximum bytes per pixel supported.
- ROW_MAX, 4096, maximum row length in bytes (row-buffer depth).
- LEN_WD, 13, width of row-length and row-count fields; must hold ROW_MAX.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  frame start pulse; samples cfg_* when IDLE.
- cfg_typ_i  in  3  filter type: 0 None, 1 Sub, 2 Up, 3 Avg, 4 Paeth.
- cfg_bpp_i  in  4  bytes per pixel, 1..BPP_MAX.
- cfg_len_i  in  LEN_WD  bytes per row, 1..ROW_MAX.
- cfg_row_i  in  LEN_WD  rows per frame, >=1.
- dat_val_i  in  1  raw byte valid.
- dat_rdy_o  out  1  raw byte accepted when val&rdy.
- dat_i  in  DATA_WD  raw byte x.
- flt_val_o  out  1  filtered byte valid.
- flt_rdy_i  in  1  downstream ready.
- flt_dat_o  out  DATA_WD  filtered byte or filter-type header.
- flt_sor_o  out  1  high with the header byte of each row.
- flt_eof_o  out  1  high with the last byte of the frame.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse after the eof byte handshakes.

Behaviour:
- Reset: state IDLE; flt_val_o, flt_sor_o, flt_eof_o, done_o, busy_o and dat_rdy_o = 0; row/col counters and history registers = 0. Row-buffer contents are don't-care because the first-row flag masks them.
- FSM: IDLE -> HEAD on start_i. HEAD loads the header byte {5'b0, typ} into the output register with flt_sor_o=1 -> BODY. BODY moves to HEAD at the end of a row, or to DONE after the last byte of the last row is loaded. DONE waits for the eof handshake, pulses done_o, then -> IDLE.
- start_i is ignored when not IDLE.
- Config legalisation: cfg_typ_i 5..7 is treated as 0, and the header emits 0. cfg_bpp_i of 0 is treated as 1; values above BPP_MAX are treated as BPP_MAX. Config is latched and held for the whole frame.
- Output register: single stage. dat_rdy_o = (state==BODY) & (~flt_val_o | flt_rdy_i). Filtered byte x' appears on flt_dat_o the cycle after the input handshake, so latency is 1 cycle. Holding flt_val_o and flt_rdy_i both high sustains 1 byte/cycle, except for 1 header cycle per row.
- Neighbours at column i: b = rowbuf[i]; a = left history at i-bpp; c = up history at i-bpp. For i < bpp, a = c = 0. For row 0, b = c = 0.
- History: left and up shift registers, each BPP_MAX deep, tapped at bpp-1. Both are cleared at every row start.
- Row buffer: read-before-write at index i. The raw x (not x') is written on the input handshake.
- Arithmetic, all mod 2^DATA_WD:
  - None: x.
  - Sub: x-a.
  - Up: x-b.
  - Avg: x-((a+b)>>1), with a DATA_WD+1-bit sum.
  - Paeth: x-P(a,b,c), with pa=|b-c|, pb=|a-c|, pc=|a+b-2c|. Ties resolve to a, then b, then c.
- Stall: while flt_rdy_i=0 and flt_val_o=1, the output byte, flags and all counters hold.
- Reset mid-frame: returns to IDLE next cycle; any pending output byte is dropped without a handshake.
- Single-byte rows (cfg_len_i=1) and single-row frames must work. flt_eof_o asserts on the last data byte, never on a header.

Decomposition:
- Shared package: filter-type encodings (FLT_NONE..FLT_PAETH), FSM state encoding, DATA_WD default.
- One sub-module, filter_pred: combinational; inputs x,a,b,c,typ; output x'. It contains the Paeth predictor.
- The row buffer is an inline register array (1R1W, asynchronous read).

Test Plan:
- Type 0, bpp=1, len=4, rows=1, input 10,20,30,40 -> outputs 00,10,20,30,40; sor on 00, eof on 40; done pulses once.
- Type 1, bpp=3, len=6, input 1,2,3,5,7,9 -> 01,1,2,3,4,5,6.
- Type 2, len=3, rows=2, row0 5,5,5, row1 8,3,255 -> row0 02,5,5,5; row1 02,3,254,250.
- Type 3 (bpp=1, len=2, rows=2, rows 100,200 / 50,250) gives 03,100,150 / 03,0,125. Type 4 (same rows) gives 04,100,100 / 04,206,50.
- Random flt_rdy_i backpressure on a 64x4 Paeth frame -> output matches the reference model byte-for-byte; no loss or duplication; dat_rdy_o low whenever flt_val_o&~flt_rdy_i.
- rst asserted mid-row 1, then a new start with cfg_typ_i=6 -> header 00; row 0 uses b=c=0; start_i pulses while busy have no effect.
